// File: rtl/leaf_switch.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_switch
//  Purpose  : Router-side endpoint for one group of four GPU network-interface
//             leaves. Each of the five inputs (leaves 0..3 and the uplink) is
//             buffered in its own FIFO. The 6-bit header at the top of each
//             head flit selects the destination. Flits for this group are
//             ejected to a leaf. Leaf flits for other groups go to the uplink.
//             Invalid or misrouted flits are dropped and counted.
//  Ports    : clk, reset_n        - clock, async active-low reset
//             lc_data_in/valid_in - flits from leaves (slice i*DATA_W)
//             lc_ready_out        - leaf FIFO has headroom
//             ej_data_out/valid   - registered one-cycle eject pulses
//             up_data_in/valid_in - flits arriving from the uplink
//             up_ready_out        - uplink FIFO has headroom
//             up_data_out/valid   - registered uplink output, valid/ready
//             up_ready_in         - uplink accepts the current flit
//             drop_count          - saturating drop counter
//  Revision : 1.0 - initial release
// ============================================================================
module leaf_switch #(
  parameter int GROUP_ID   = 1,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DATA_W-1:0]   lc_data_in,
  input  logic [3:0]            lc_valid_in,
  output logic [3:0]            lc_ready_out,
  output logic [4*DATA_W-1:0]   ej_data_out,
  output logic [3:0]            ej_valid_out,
  input  logic [DATA_W-1:0]     up_data_in,
  input  logic                  up_valid_in,
  output logic                  up_ready_out,
  output logic [DATA_W-1:0]     up_data_out,
  output logic                  up_valid_out,
  input  logic                  up_ready_in,
  output logic [CNT_W-1:0]      drop_count
);

  localparam int          c_NIN   = 5;  // leaves 0..3, then uplink (index 4)
  localparam int          c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int          c_OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0]  c_GROUP = 4'(GROUP_ID);
  localparam logic [CNT_W+3:0] c_CNT_MAX = {4'b0, {CNT_W{1'b1}}};

  logic [DATA_W-1:0]         w_in_data [c_NIN];
  logic [c_NIN-1:0]          w_in_valid;
  logic [DATA_W-1:0]         w_head    [c_NIN];
  logic [c_NIN-1:0]          w_head_vld;
  logic [c_NIN-1:0]          w_ready;
  logic [c_NIN-1:0]          w_ovf;     // push attempted into a full FIFO
  logic [c_NIN-1:0]          w_bad;     // head popped as invalid/misrouted
  logic [c_NIN-1:0]          w_pop;
  logic [c_NIN-1:0][c_NIN-1:0] w_req;   // [output][input]
  logic [c_NIN-1:0]          w_out_rdy;
  logic [c_NIN-1:0]          w_gnt_vld;
  logic [2:0]                w_gnt_idx  [c_NIN];
  logic [DATA_W-1:0]         w_gnt_data [c_NIN];
  logic [3:0]                w_ndrop;
  logic [CNT_W+3:0]          w_cnt_sum;

  logic [2:0]                arb_ptr_q [c_NIN];
  logic [4*DATA_W-1:0]       ej_data_q;
  logic [3:0]                ej_valid_q;
  logic [DATA_W-1:0]         up_data_q;
  logic                      up_valid_q;
  logic [CNT_W-1:0]          drop_q, drop_d;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_in_data[j]  = lc_data_in[j*DATA_W +: DATA_W];
      w_in_valid[j] = lc_valid_in[j];
    end
    w_in_data[4]  = up_data_in;
    w_in_valid[4] = up_valid_in;
  end

  // --------------------------------------------------------------------------
  // Input FIFOs
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < c_NIN; j++) begin : g_fifo
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_q, rd_q;
    logic [c_OCC_W-1:0] occ_q;
    logic               w_full, w_push;

    assign w_full        = (occ_q == c_OCC_W'(FIFO_DEPTH));
    assign w_push        = w_in_valid[j] && !w_full;
    assign w_ovf[j]      = w_in_valid[j] && w_full;
    assign w_head[j]     = mem_q[rd_q];
    assign w_head_vld[j] = (occ_q != '0);
    // One slot of headroom absorbs a flit launched against a stale ready.
    assign w_ready[j]    = (occ_q <= c_OCC_W'(FIFO_DEPTH - 2));

    always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_q] <= w_in_data[j];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        occ_q <= '0;
      end else begin
        if (w_push)
          wr_q <= (wr_q == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + c_PTR_W'(1);
        if (w_pop[j])
          rd_q <= (rd_q == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + c_PTR_W'(1);
        if (w_push && !w_pop[j])
          occ_q <= occ_q + c_OCC_W'(1);
        else if (!w_push && w_pop[j])
          occ_q <= occ_q - c_OCC_W'(1);
      end
    end
  end

  assign lc_ready_out = w_ready[3:0];
  assign up_ready_out = w_ready[4];

  // --------------------------------------------------------------------------
  // Header decode: each head requests exactly one output or is discarded
  // --------------------------------------------------------------------------
  always_comb begin
    logic [5:0] hdr;
    hdr   = '0;
    w_req = '0;
    w_bad = '0;
    for (int j = 0; j < c_NIN; j++) begin
      hdr = w_head[j][DATA_W-1 -: 6];
      if (w_head_vld[j]) begin
        if (hdr == 6'd0)
          w_bad[j] = 1'b1;
        else if (hdr[5:2] == c_GROUP)
          w_req[{1'b0, hdr[1:0]}][j] = 1'b1;
        else if (j < 4)
          w_req[4][j] = 1'b1;
        else
          w_bad[j] = 1'b1;  // uplink flit addressed to another group
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin arbiters, one per output. Scanning from the highest offset
  // down lets the lowest offset from the pointer win.
  // --------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx       = 0;
    w_out_rdy = {(!up_valid_q || up_ready_in), 4'hF};
    w_pop     = w_bad;
    for (int o = 0; o < c_NIN; o++) begin
      w_gnt_vld[o] = 1'b0;
      w_gnt_idx[o] = '0;
      for (int k = c_NIN - 1; k >= 0; k--) begin
        idx = int'(arb_ptr_q[o]) + k;
        if (idx >= c_NIN) idx = idx - c_NIN;
        if (w_out_rdy[o] && w_req[o][idx]) begin
          w_gnt_vld[o] = 1'b1;
          w_gnt_idx[o] = 3'(idx);
        end
      end
      w_gnt_data[o] = w_head[w_gnt_idx[o]];
      if (w_gnt_vld[o]) w_pop[w_gnt_idx[o]] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Drop counter: all sources in a cycle are summed, then saturated
  // --------------------------------------------------------------------------
  always_comb begin
    w_ndrop = '0;
    for (int j = 0; j < c_NIN; j++)
      w_ndrop = w_ndrop + 4'(w_ovf[j]) + 4'(w_bad[j]);
    w_cnt_sum = {4'b0, drop_q} + {{CNT_W{1'b0}}, w_ndrop};
    drop_d    = (w_cnt_sum > c_CNT_MAX) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
  end

  // --------------------------------------------------------------------------
  // Registered outputs and arbiter pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int o = 0; o < c_NIN; o++) arb_ptr_q[o] <= '0;
      ej_data_q  <= '0;
      ej_valid_q <= '0;
      up_data_q  <= '0;
      up_valid_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      for (int o = 0; o < c_NIN; o++)
        if (w_gnt_vld[o])
          arb_ptr_q[o] <= (w_gnt_idx[o] == 3'd4) ? 3'd0 : w_gnt_idx[o] + 3'd1;
      for (int o = 0; o < 4; o++) begin
        ej_valid_q[o] <= w_gnt_vld[o];
        if (w_gnt_vld[o]) ej_data_q[o*DATA_W +: DATA_W] <= w_gnt_data[o];
      end
      if (!up_valid_q || up_ready_in) begin
        up_valid_q <= w_gnt_vld[4];
        if (w_gnt_vld[4]) up_data_q <= w_gnt_data[4];
      end
      drop_q <= drop_d;
    end
  end

  assign ej_data_out  = ej_data_q;
  assign ej_valid_out = ej_valid_q;
  assign up_data_out  = up_data_q;
  assign up_valid_out = up_valid_q;
  assign drop_count   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_leaf_switch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_leaf_switch
//  Purpose  : Directed self-checking bench for leaf_switch (GROUP_ID=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_switch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] lc_data_in = '0;
  logic [3:0]  lc_valid_in = '0;
  logic [3:0]  lc_ready_out;
  logic [63:0] ej_data_out;
  logic [3:0]  ej_valid_out;
  logic [15:0] up_data_in = '0;
  logic        up_valid_in = 1'b0;
  logic        up_ready_out;
  logic [15:0] up_data_out;
  logic        up_valid_out;
  logic        up_ready_in = 1'b1;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fails  = 0;

  leaf_switch #(
    .GROUP_ID   (2),
    .DATA_W     (16),
    .FIFO_DEPTH (4),
    .CNT_W      (8)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .lc_data_in   (lc_data_in),
    .lc_valid_in  (lc_valid_in),
    .lc_ready_out (lc_ready_out),
    .ej_data_out  (ej_data_out),
    .ej_valid_out (ej_valid_out),
    .up_data_in   (up_data_in),
    .up_valid_in  (up_valid_in),
    .up_ready_out (up_ready_out),
    .up_data_out  (up_data_out),
    .up_valid_out (up_valid_out),
    .up_ready_in  (up_ready_in),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs/outputs are touched 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] got_q [6];
  int sent, ngot, stale;

  initial begin
    // ---------------- reset state ----------------
    #2;
    check("rst_ej_valid", 64'(ej_valid_out), 64'h0);
    check("rst_up_valid", 64'(up_valid_out), 64'h0);
    check("rst_up_data",  64'(up_data_out),  64'h0);
    check("rst_ej_data",  ej_data_out,       64'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_lc_ready", 64'(lc_ready_out), 64'hF);
    check("rst_up_ready", 64'(up_ready_out), 64'h1);
    check("rst_drop",     64'(drop_count),   64'h0);

    // ---------------- 1: local eject leaf0 -> leaf3 ----------------
    lc_data_in[15:0] = 16'h2C55; lc_valid_in = 4'b0001;
    tick();
    lc_valid_in = '0;
    check("t1_not_yet", 64'(ej_valid_out), 64'h0);
    tick();
    check("t1_ej_valid", 64'(ej_valid_out), 64'h8);
    check("t1_ej_data",  64'(ej_data_out[63:48]), 64'h2C55);
    check("t1_up_idle",  64'(up_valid_out), 64'h0);
    tick();
    check("t1_one_cycle", 64'(ej_valid_out), 64'h0);
    check("t1_data_hold", 64'(ej_data_out[63:48]), 64'h2C55);

    // ---------------- 2: uplink stall ----------------
    up_ready_in = 1'b0;
    lc_data_in[31:16] = 16'h1001; lc_valid_in = 4'b0010;
    tick();
    lc_valid_in = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_stall_valid", 64'(up_valid_out), 64'h1);
      check("t2_stall_data",  64'(up_data_out),  64'h1001);
    end
    up_ready_in = 1'b1;
    tick();
    check("t2_after_xfer", 64'(up_valid_out), 64'h0);
    check("t2_ej_idle",    64'(ej_valid_out), 64'h0);
    check("t2_drop",       64'(drop_count),   64'h0);

    // ---------------- 3: three-way contention for leaf1 ----------------
    for (int b = 0; b < 2; b++) begin
      lc_data_in[15:0]  = 16'h2400 + 16'(b * 16'h30);
      lc_data_in[31:16] = 16'h2411 + 16'(b * 16'h30);
      lc_data_in[47:32] = 16'h2422 + 16'(b * 16'h30);
      lc_valid_in = 4'b0111;
      tick();
      lc_valid_in = '0;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("t3_ej1_valid", 64'(ej_valid_out), 64'h2);
        check("t3_ej1_order", 64'(ej_data_out[31:16]),
              64'(16'h2400 + 16'(b * 16'h30) + 16'(k * 16'h11)));
      end
      tick();
      check("t3_burst_end", 64'(ej_valid_out), 64'h0);
    end

    // ---------------- 4: uplink backpressure fills leaf0 FIFO ----------------
    sent = 0; ngot = 0;
    up_ready_in = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      lc_valid_in = '0;
      if (lc_ready_out[0] && sent < 6) begin
        lc_data_in[15:0] = 16'h3000 + 16'(sent); lc_valid_in = 4'b0001; sent++;
      end
      tick();
    end
    lc_valid_in = '0;
    // One flit in the output register plus three queued holds ready low.
    check("t4_sent_before_full", 64'(sent), 64'd4);
    check("t4_ready_low",        64'(lc_ready_out[0]), 64'h0);
    up_ready_in = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      lc_valid_in = '0;
      if (lc_ready_out[0] && sent < 6) begin
        lc_data_in[15:0] = 16'h3000 + 16'(sent); lc_valid_in = 4'b0001; sent++;
      end
      if (up_valid_out && up_ready_in) begin
        if (ngot < 6) got_q[ngot] = up_data_out;
        ngot++;
      end
      tick();
    end
    lc_valid_in = '0;
    check("t4_count", 64'(ngot), 64'd6);
    for (int k = 0; k < 6; k++)
      check("t4_order", 64'(got_q[k]), 64'(16'h3000 + 16'(k)));
    check("t4_drop", 64'(drop_count), 64'h0);

    // ---------------- 5: drops ----------------
    lc_data_in[47:32] = 16'h0123; lc_valid_in = 4'b0100;
    tick();
    lc_valid_in = '0;
    tick();
    check("t5_hdr0_drop",  64'(drop_count),   64'd1);
    check("t5_hdr0_noej",  64'(ej_valid_out), 64'h0);
    check("t5_hdr0_noup",  64'(up_valid_out), 64'h0);
    up_data_in = 16'h5000; up_valid_in = 1'b1;
    tick();
    up_valid_in = 1'b0;
    tick();
    check("t5_misroute_drop", 64'(drop_count),   64'd2);
    check("t5_misroute_noej", 64'(ej_valid_out), 64'h0);
    lc_data_in = '0; up_data_in = '0;
    lc_valid_in = 4'hF; up_valid_in = 1'b1;
    for (int i = 0; i < 70; i++) tick();
    lc_valid_in = '0; up_valid_in = 1'b0;
    check("t5_saturate", 64'(drop_count), 64'd255);
    tick(); tick();
    check("t5_hold_sat", 64'(drop_count), 64'd255);

    // ---------------- 6: asynchronous reset mid-operation ----------------
    up_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lc_data_in[15:0] = 16'h3100 + 16'(k); lc_valid_in = 4'b0001;
      tick();
    end
    lc_valid_in = '0;
    tick();
    check("t6_pre_valid", 64'(up_valid_out), 64'h1);
    #1 reset_n = 1'b0;
    #1;
    check("t6_async_up_valid", 64'(up_valid_out), 64'h0);
    check("t6_async_up_data",  64'(up_data_out),  64'h0);
    check("t6_async_ej_data",  ej_data_out,       64'h0);
    check("t6_async_drop",     64'(drop_count),   64'h0);
    tick(); tick();
    reset_n = 1'b1;
    up_ready_in = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (up_valid_out || (ej_valid_out != 4'h0)) stale++;
    end
    check("t6_no_stale",  64'(stale),        64'd0);
    check("t6_lc_ready",  64'(lc_ready_out), 64'hF);
    check("t6_up_ready",  64'(up_ready_out), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
